display_mux: RTL and testbench

DISPLAY_MUX -- requirements
Module: display_mux

---
 rtl/display_mux.sv | 96 +++++++++
 tb/tb_display_mux.sv | 135 +++++++++++++
 2 files changed

// File: rtl/display_mux.sv
// Time-multiplexed driver for an 8-digit, active-low seven-segment display.
// Holds a digit buffer, scans one digit every DIV clocks and overlays calculator status.
module display_mux #(
  parameter int DIV  = 1000,
  parameter int NDIG = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [3:0]      pos,
  input  logic [3:0]      data,
  input  logic            clr,
  input  logic [1:0]      status,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg,
  output logic            dp
);

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
  localparam logic [1:0]  ST_BUSY  = 2'b01;
  localparam logic [1:0]  ST_ERR   = 2'b10;

  logic [3:0]      dig_q [NDIG];
  logic [3:0]      dig_d [NDIG];
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            tick;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h3F;
      4'hB:    g = 7'h06;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  always_comb begin
    dig_d = dig_q;
    if (clr) begin
      for (int i = 0; i < NDIG; i++) dig_d[i] = 4'hF;
    end else if (wr_en && pos < 4'(NDIG)) begin
      dig_d[pos[2:0]] = data;
    end
  end

  // Scan timing runs free of writes, clears and status changes.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d = tick ? idx_q + 3'd1 : idx_q;
  end

  always_comb begin
    an_d  = ~(NDIG'(1) << idx_q);
    seg_d = (status == ST_ERR) ? 7'h06 : glyph(dig_q[idx_q]);
    dp_d  = !((status == ST_BUSY) && (idx_q == 3'd0));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NDIG; i++) dig_q[i] <= 4'hF;
      cnt_q <= 16'd0;
      idx_q <= 3'd0;
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      dig_q <= dig_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: directed scenarios plus random traffic, checked every cycle
// against a model that derives the scanned digit from the count of cycles since reset.
module tb_display_mux;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] pos = 4'd0;
  logic [3:0] data = 4'd0;
  logic       clr = 1'b0;
  logic [1:0] status = 2'b00;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  display_mux #(.DIV(DIV), .NDIG(8)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .pos(pos), .data(data),
    .clr(clr), .status(status), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clock = ~clock;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h06, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  int         total_checks = 0;
  int         pass_checks = 0;
  int         cycles_run = 0;
  logic [3:0] model_dig [8];
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  function automatic int scan_digit(input int n);
    return (n / DIV) % 8;
  endfunction

  task automatic checkOutput(input string tag);
    total_checks++;
    assert (an === exp_an) pass_checks++;
    else $error("[TB] FAIL %s.an cycle=%0d observed=%h expected=%h", tag, cycles_run, an, exp_an);
    total_checks++;
    assert (seg === exp_seg) pass_checks++;
    else $error("[TB] FAIL %s.seg cycle=%0d observed=%h expected=%h", tag, cycles_run, seg, exp_seg);
    total_checks++;
    assert (dp === exp_dp) pass_checks++;
    else $error("[TB] FAIL %s.dp cycle=%0d observed=%b expected=%b", tag, cycles_run, dp, exp_dp);
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic w,
                               input logic [3:0] p, input logic [3:0] d,
                               input logic c, input logic [1:0] s);
    int cur;
    reset = r; wr_en = w; pos = p; data = d; clr = c; status = s;
    @(posedge clock);
    if (!r) begin
      cycles_run = 0;
      foreach (model_dig[i]) model_dig[i] = 4'hF;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      cur     = scan_digit(cycles_run);
      exp_an  = ~(8'h01 << cur);
      exp_seg = (s == 2'b10) ? 7'h06 : glyph_tab[model_dig[cur]];
      exp_dp  = !(s == 2'b01 && cur == 0);
      if (c) foreach (model_dig[i]) model_dig[i] = 4'hF;
      else if (w && p < 4'd8) model_dig[p] = d;
      cycles_run++;
    end
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic [1:0] s);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, s);
  endtask

  task automatic idle_until_digit(input string tag, input int target, input logic [1:0] s);
    for (int i = 0; i < 8 * DIV + 1 && scan_digit(cycles_run) != target; i++)
      applyStimulus(tag, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, s);
  endtask

  initial begin
    logic r, w, c;
    logic [3:0] p, d;
    logic [1:0] s;

    applyStimulus("reset", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
    applyStimulus("reset_hold", 1'b0, 1'b1, 4'd1, 4'd5, 1'b0, 2'b00);
    applyStimulus("first_after_release", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00);
    idle("idle_scan", 40, 2'b00);

    idle_until_digit("seek0", 0, 2'b00);
    applyStimulus("write_d0", 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 2'b00);
    idle("write_d0_show", 2 * 8 * DIV, 2'b00);

    applyStimulus("write_pos9", 1'b1, 1'b1, 4'd9, 4'd5, 1'b0, 2'b00);
    applyStimulus("write_pos15", 1'b1, 1'b1, 4'd15, 4'd1, 1'b0, 2'b00);
    idle("ignored_scan", 8 * DIV + 2, 2'b00);

    for (int i = 0; i < 8; i++)
      applyStimulus("load", 1'b1, 1'b1, 4'(i), 4'(i + 1), 1'b0, 2'b00);
    idle("loaded_scan", 8 * DIV, 2'b00);
    applyStimulus("clr_vs_write", 1'b1, 1'b1, 4'd2, 4'd7, 1'b1, 2'b00);
    idle("cleared_scan", 8 * DIV + 2, 2'b00);

    for (int i = 0; i < 8; i++)
      applyStimulus("reload", 1'b1, 1'b1, 4'(i), 4'(9 - i), 1'b0, 2'b00);
    applyStimulus("load_glyphs", 1'b1, 1'b1, 4'd3, 4'hA, 1'b0, 2'b00);
    applyStimulus("load_glyphs", 1'b1, 1'b1, 4'd4, 4'hB, 1'b0, 2'b00);
    idle("erro", 8 * DIV + 2, 2'b10);
    idle("back_pronta", 8 * DIV + 2, 2'b00);
    idle("reserved_status", 8 * DIV, 2'b11);

    idle("ocupada", 8 * DIV + 2, 2'b01);
    idle_until_digit("seek5", 5, 2'b01);
    applyStimulus("reset_mid_scan", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b01);
    idle("after_reset", 8 * DIV + 2, 2'b01);

    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) != 0);
      w = $urandom_range(0, 1);
      p = 4'($urandom_range(0, 15));
      d = 4'($urandom);
      c = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0) ? 2'($urandom) : status;
      applyStimulus("random", r, w, p, d, c, s);
    end

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
